// File: rtl/mem_access.sv
// Data-memory access unit: validates a load/store from execute, runs one
// request/acknowledge bus transaction, and hands the raw word to the load aligner.
module mem_access #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [1:0]  resp_rem,
    output logic [2:0]  resp_info,
    output logic        resp_is_store,
    output logic [1:0]  resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    typedef enum logic [1:0] {ERR_OK, ERR_MISALIGN, ERR_ILLEGAL, ERR_TIMEOUT} err_t;

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state, state_d;
    logic [CW-1:0] cnt;
    logic          drop;
    logic          accept;
    logic          timed_out;
    err_t          dec_err;
    logic [3:0]    be_d;
    logic [31:0]   wdata_d;

    function automatic err_t decode(input logic is_store, input logic [2:0] f3,
                                    input logic [1:0] off);
        logic illegal;
        logic misaligned;
        illegal    = is_store ? (f3 > 3'b010)
                              : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        // Halfwords at offset 01 stay legal: the aligner handles that case.
        misaligned = (f3[1:0] == 2'b01 && off == 2'b11) ||
                     (f3[1:0] == 2'b10 && off != 2'b00);
        if (illegal)         return ERR_ILLEGAL;
        else if (misaligned) return ERR_MISALIGN;
        else                 return ERR_OK;
    endfunction

    assign req_ready  = (state == IDLE) && !flush;
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign timed_out  = (cnt == CNT_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dec_err = decode(req_is_store, req_funct3, req_addr[1:0]);
        be_d    = 4'b1111;
        wdata_d = 32'h0;
        if (req_is_store) begin
            wdata_d = req_wdata << {req_addr[1:0], 3'b000};
            case (req_funct3[1:0])
                2'b00:   be_d = 4'b0001 << req_addr[1:0];
                2'b01:   be_d = 4'b0011 << req_addr[1:0];
                default: be_d = 4'b1111;
            endcase
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: if (accept) state_d = (dec_err == ERR_OK) ? REQ : RESP;
            REQ:  if (dmem_ack || timed_out) state_d = (drop || flush) ? IDLE : RESP;
            RESP: if (resp_ready || flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            drop          <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= 32'h0;
            dmem_wdata    <= 32'h0;
            dmem_be       <= 4'h0;
            resp_data     <= 32'h0;
            resp_rem      <= 2'b00;
            resp_info     <= 3'b000;
            resp_is_store <= 1'b0;
            resp_err      <= 2'b00;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt           <= '0;
                        drop          <= 1'b0;
                        resp_data     <= 32'h0;
                        resp_rem      <= req_addr[1:0];
                        resp_info     <= req_funct3;
                        resp_is_store <= req_is_store;
                        resp_err      <= dec_err;
                        if (dec_err == ERR_OK) begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= req_is_store;
                            dmem_addr  <= {req_addr[31:2], 2'b00};
                            dmem_wdata <= wdata_d;
                            dmem_be    <= be_d;
                        end
                    end
                end
                REQ: begin
                    // The bus op is never retracted; a flush only suppresses the response.
                    drop <= drop || flush;
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        resp_err <= ERR_OK;
                        if (!resp_is_store) resp_data <= dmem_rdata;
                    end else if (timed_out) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        resp_err <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads, stores, decode errors, timeout,
// flush, backpressure, throughput and asynchronous reset.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        flush;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_rem;
    logic [2:0]  resp_info;
    logic        resp_is_store;
    logic [1:0]  resp_err;

    int checks = 0;
    int errors = 0;

    mem_access #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_rem(resp_rem), .resp_info(resp_info), .resp_is_store(resp_is_store),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Present one op for a single accept edge; returns at the negedge of cycle T+1.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, resp_valid, resp_data,
             resp_rem, resp_info, resp_is_store, resp_err, req_ready} !== {77'h0, 32'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: req=%b addr=%h be=%h rv=%b err=%b ready=%b, need all 0 and ready=1",
                     dmem_req, dmem_addr, dmem_be, resp_valid, resp_err, req_ready);
        end
        flush = 1'b1; #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL reset_flush_ready: got %b need 0", req_ready);
        end
        flush = 1'b0;
    endtask

    task automatic test_load_byte();
        issue(1'b0, 3'b000, 32'h1003, 32'h0);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, resp_valid} !==
            {1'b1, 1'b0, 32'h1000, 4'hF, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL lb_bus: req=%b we=%b addr=%h be=%h wd=%h rv=%b need 1 0 00001000 f 00000000 0",
                     dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, resp_valid);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h80AABBCC;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({resp_valid, resp_data, resp_rem, resp_info, resp_err, resp_is_store, dmem_req} !==
            {1'b1, 32'h80AABBCC, 2'b11, 3'b000, 2'b00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL lb_resp: rv=%b data=%h rem=%b info=%b err=%b st=%b req=%b need 1 80aabbcc 11 000 00 0 0",
                     resp_valid, resp_data, resp_rem, resp_info, resp_err, resp_is_store, dmem_req);
        end
        drain();
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL lb_done: rv=%b ready=%b need 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        issue(1'b1, f3, a, wd);
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata} !==
            {1'b1, 1'b1, {a[31:2], 2'b00}, exp_be, exp_wd}) begin
            errors++;
            $display("FAIL store_bus f3=%b a=%h: req=%b we=%b addr=%h be=%b wd=%h need be=%b wd=%h",
                     f3, a, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, exp_be, exp_wd);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({resp_valid, resp_data, resp_err, resp_is_store, resp_info, resp_rem} !==
            {1'b1, 32'h0, 2'b00, 1'b1, f3, a[1:0]}) begin
            errors++;
            $display("FAIL store_resp f3=%b: rv=%b data=%h err=%b st=%b info=%b rem=%b",
                     f3, resp_valid, resp_data, resp_err, resp_is_store, resp_info, resp_rem);
        end
        drain();
    endtask

    task automatic test_store();
        run_store(3'b001, 32'h2001, 32'h0000BEEF, 4'b0110, 32'h00BEEF00);
        run_store(3'b000, 32'h3002, 32'h12345678, 4'b0100, 32'h56780000);
        run_store(3'b010, 32'h4000, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);
    endtask

    task automatic run_err(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [1:0] exp_err);
        issue(st, f3, a, 32'hFFFFFFFF);
        checks++;
        if ({resp_valid, dmem_req, resp_err, resp_data} !== {1'b1, 1'b0, exp_err, 32'h0}) begin
            errors++;
            $display("FAIL decode_err st=%b f3=%b a=%h: rv=%b req=%b err=%b data=%h need 1 0 %b 0",
                     st, f3, a, resp_valid, dmem_req, resp_err, resp_data, exp_err);
        end
        drain();
    endtask

    task automatic test_errors();
        run_err(1'b0, 3'b010, 32'h0002, 2'b01);
        run_err(1'b0, 3'b001, 32'h0003, 2'b01);
        run_err(1'b1, 3'b010, 32'h0001, 2'b01);
        run_err(1'b0, 3'b011, 32'h0000, 2'b10);
        run_err(1'b1, 3'b100, 32'h0000, 2'b10);
        run_err(1'b0, 3'b111, 32'h0003, 2'b10);
        // LHU at offset 01 is legal and must go to the bus.
        issue(1'b0, 3'b101, 32'h0001, 32'h0);
        checks++;
        if ({dmem_req, resp_valid} !== 2'b10) begin
            errors++; $display("FAIL lhu_off1: req=%b rv=%b need 1 0", dmem_req, resp_valid);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h0000A5A5;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({resp_valid, resp_err, resp_data} !== {1'b1, 2'b00, 32'h0000A5A5}) begin
            errors++;
            $display("FAIL lhu_resp: rv=%b err=%b data=%h", resp_valid, resp_err, resp_data);
        end
        drain();
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b0, 3'b010, 32'h0100, 32'h0);
        n = 0;
        for (int i = 0; i < 10 && dmem_req; i++) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL timeout_len: req high %0d cycles need 4", n);
        end
        checks++;
        if ({resp_valid, resp_err, resp_data} !== {1'b1, 2'b11, 32'h0}) begin
            errors++;
            $display("FAIL timeout_resp: rv=%b err=%b data=%h need 1 11 0", resp_valid, resp_err, resp_data);
        end
        drain();
        // Ack in the last allowed cycle wins over the timeout.
        issue(1'b0, 3'b010, 32'h0200, 32'h0);
        repeat (3) @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'h01020304;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({resp_valid, resp_err, resp_data} !== {1'b1, 2'b00, 32'h01020304}) begin
            errors++;
            $display("FAIL ack_last_cycle: rv=%b err=%b data=%h need 1 00 01020304", resp_valid, resp_err, resp_data);
        end
        drain();
    endtask

    task automatic test_flush();
        issue(1'b0, 3'b010, 32'h0300, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({dmem_req, resp_valid} !== 2'b10) begin
            errors++; $display("FAIL flush_hold: req=%b rv=%b need 1 0", dmem_req, resp_valid);
        end
        dmem_ack = 1'b1; dmem_rdata = 32'h99999999;
        @(negedge clk);
        dmem_ack = 1'b0;
        checks++;
        if ({dmem_req, resp_valid, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL flush_drop: req=%b rv=%b ready=%b need 0 0 1", dmem_req, resp_valid, req_ready);
        end
        // Flush while a response is waiting discards it.
        issue(1'b0, 3'b011, 32'h0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            errors++; $display("FAIL flush_resp: rv=%b ready=%b need 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_backpressure();
        issue(1'b0, 3'b100, 32'h0042, 32'h0);
        dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
        @(negedge clk);
        dmem_ack = 1'b0; dmem_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({resp_valid, req_ready, resp_data, resp_rem, resp_info, resp_err, resp_is_store} !==
                {1'b1, 1'b0, 32'h11223344, 2'b10, 3'b100, 2'b00, 1'b0}) begin
                errors++;
                $display("FAIL backpressure_cyc%0d: rv=%b ready=%b data=%h rem=%b info=%b err=%b",
                         i, resp_valid, req_ready, resp_data, resp_rem, resp_info, resp_err);
            end
            @(negedge clk);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        dmem_ack = 1'b1; dmem_rdata = 32'h55; resp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        req_valid = 1'b0; dmem_ack = 1'b0; resp_ready = 1'b0;
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL back_to_back: %0d responses in 9 cycles need 3", n);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 3'b010, 32'h0500, 32'h12345678);
        rst = 1'b1;
        #1;
        checks++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, resp_valid, resp_data,
             resp_rem, resp_info, resp_is_store, resp_err} !== 109'h0) begin
            errors++;
            $display("FAIL reset_mid: req=%b we=%b addr=%h wd=%h be=%b rv=%b need all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({req_ready, dmem_req} !== 2'b10) begin
            errors++; $display("FAIL reset_mid_idle: ready=%b req=%b need 1 0", req_ready, dmem_req);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0; dmem_ack = 1'b0;
        dmem_rdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_load_byte();
        test_store();
        test_errors();
        test_timeout();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
